// File: rtl/debug_unit_if.sv
// Host debug bundle between debug_unit and its UART, processor core and instruction memory.
// master = debug_unit side, slave = the surrounding UART/core/memory side.
interface debug_unit_if #(
    parameter int PC_W = 10
);
    logic [7:0]      rx_data;
    logic            rx_done;
    logic [7:0]      tx_data;
    logic            tx_start;
    logic            tx_done;
    logic            mips_enable;
    logic            mips_reset;
    logic            halt;
    logic [PC_W-1:0] pc_value;
    logic [4:0]      dbg_reg_addr;
    logic [31:0]     dbg_reg_data;
    logic            imem_we;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_wdata;

    modport master (
        input  rx_data, rx_done, tx_done, halt, pc_value, dbg_reg_data,
        output tx_data, tx_start, mips_enable, mips_reset, dbg_reg_addr,
               imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output rx_data, rx_done, tx_done, halt, pc_value, dbg_reg_data,
        input  tx_data, tx_start, mips_enable, mips_reset, dbg_reg_addr,
               imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/debug_unit.sv
// Host debug stage: UART command decode, program load, run/step gating of the core, state dump.
// Every output is registered one cycle after the decision; each tx byte waits for tx_done.
module debug_unit #(
    parameter int PC_W  = 10,
    parameter int NREGS = 32
) (
    input  logic         clock,
    input  logic         reset,
    debug_unit_if.master bus
);
    localparam int IDX_W = $clog2(NREGS + 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS + 1);

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_RST  = 8'h52;
    localparam logic [7:0] ACK_BYTE = 8'h06;

    typedef enum logic [3:0] {
        IDLE, LD_HI, LD_LO, LD_BYTE, LD_WR, RUN, STEP, RST,
        DUMP_LOAD, DUMP_SEND, DUMP_WAIT, ACK_SEND, ACK_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] n_q, n_d;
    logic [PC_W-1:0] n_load;
    logic [PC_W-1:0] addr_q, addr_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [31:0]     word_q, word_d;
    logic [31:0]     shift_q, shift_d;
    logic [2:0]      bytes_left_q, bytes_left_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic            phase_q, phase_d;
    logic [31:0]     cycle_cnt_q, cycle_cnt_d;
    logic [15:0]     pc_ext;

    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_start_q, tx_start_d;
    logic            mips_enable_q, mips_enable_d;
    logic            mips_reset_q, mips_reset_d;
    logic [4:0]      dbg_reg_addr_q, dbg_reg_addr_d;
    logic            imem_we_q, imem_we_d;
    logic [PC_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]     imem_wdata_q, imem_wdata_d;

    assign pc_ext = 16'(bus.pc_value);
    // Only the low PC_W bits of the 16-bit word count are meaningful.
    assign n_load = PC_W'({word_q[7:0], bus.rx_data});

    always_comb begin
        state_d        = state_q;
        n_d            = n_q;
        addr_d         = addr_q;
        byte_idx_d     = byte_idx_q;
        word_d         = word_q;
        shift_d        = shift_q;
        bytes_left_d   = bytes_left_q;
        idx_d          = idx_q;
        phase_d        = phase_q;
        cycle_cnt_d    = cycle_cnt_q + 32'(mips_enable_q);
        tx_data_d      = tx_data_q;
        tx_start_d     = 1'b0;
        mips_enable_d  = 1'b0;
        mips_reset_d   = 1'b0;
        dbg_reg_addr_d = dbg_reg_addr_q;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;

        case (state_q)
            IDLE: begin
                if (bus.rx_done) begin
                    case (bus.rx_data)
                        CMD_LOAD: state_d = LD_HI;
                        CMD_RUN:  state_d = RUN;
                        CMD_STEP: begin
                            state_d = STEP;
                            phase_d = 1'b0;
                        end
                        CMD_RST:  state_d = RST;
                        default:  state_d = IDLE;
                    endcase
                end
            end
            LD_HI: begin
                if (bus.rx_done) begin
                    word_d  = {24'h0, bus.rx_data};
                    state_d = LD_LO;
                end
            end
            LD_LO: begin
                if (bus.rx_done) begin
                    n_d        = n_load;
                    addr_d     = '0;
                    byte_idx_d = 2'd0;
                    state_d    = (n_load == '0) ? ACK_SEND : LD_BYTE;
                end
            end
            LD_BYTE: begin
                if (bus.rx_done) begin
                    word_d     = {word_q[23:0], bus.rx_data};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = LD_WR;
                    end
                end
            end
            LD_WR: begin
                imem_we_d    = 1'b1;
                imem_addr_d  = addr_q;
                imem_wdata_d = word_q;
                addr_d       = addr_q + PC_W'(1);
                n_d          = n_q - PC_W'(1);
                byte_idx_d   = 2'd0;
                state_d      = (n_q == PC_W'(1)) ? ACK_SEND : LD_BYTE;
            end
            RUN: begin
                // The enable already in flight when halt is seen still lands.
                if (bus.halt) begin
                    idx_d   = '0;
                    state_d = DUMP_LOAD;
                end else begin
                    mips_enable_d = 1'b1;
                end
            end
            STEP: begin
                // Second cycle lets the enabled edge (and cycle_cnt) settle before the dump.
                if (!phase_q) begin
                    mips_enable_d = ~bus.halt;
                    phase_d       = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    idx_d   = '0;
                    state_d = DUMP_LOAD;
                end
            end
            RST: begin
                mips_reset_d = 1'b1;
                cycle_cnt_d  = '0;
                state_d      = ACK_SEND;
            end
            DUMP_LOAD: begin
                if (idx_q == '0) begin
                    shift_d      = {pc_ext, 16'h0};
                    bytes_left_d = 3'd2;
                end else if (idx_q == IDX_W'(1)) begin
                    shift_d      = cycle_cnt_q;
                    bytes_left_d = 3'd4;
                end else begin
                    shift_d      = bus.dbg_reg_data;
                    bytes_left_d = 3'd4;
                end
                state_d = DUMP_SEND;
            end
            DUMP_SEND: begin
                tx_data_d    = shift_q[31:24];
                tx_start_d   = 1'b1;
                shift_d      = {shift_q[23:0], 8'h0};
                bytes_left_d = bytes_left_q - 3'd1;
                state_d      = DUMP_WAIT;
            end
            DUMP_WAIT: begin
                if (bus.tx_done) begin
                    if (bytes_left_q != 3'd0) begin
                        state_d = DUMP_SEND;
                    end else if (idx_q == LAST_IDX) begin
                        idx_d          = '0;
                        dbg_reg_addr_d = 5'd0;
                        state_d        = IDLE;
                    end else begin
                        // Register address leads DUMP_LOAD by a cycle so the read data is stable.
                        if (idx_q != '0) begin
                            dbg_reg_addr_d = 5'(idx_q - IDX_W'(1));
                        end
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = DUMP_LOAD;
                    end
                end
            end
            ACK_SEND: begin
                tx_data_d  = ACK_BYTE;
                tx_start_d = 1'b1;
                state_d    = ACK_WAIT;
            end
            ACK_WAIT: begin
                if (bus.tx_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            n_q            <= '0;
            addr_q         <= '0;
            byte_idx_q     <= 2'd0;
            word_q         <= '0;
            shift_q        <= '0;
            bytes_left_q   <= 3'd0;
            idx_q          <= '0;
            phase_q        <= 1'b0;
            cycle_cnt_q    <= '0;
            tx_data_q      <= 8'h0;
            tx_start_q     <= 1'b0;
            mips_enable_q  <= 1'b0;
            mips_reset_q   <= 1'b0;
            dbg_reg_addr_q <= 5'd0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            addr_q         <= addr_d;
            byte_idx_q     <= byte_idx_d;
            word_q         <= word_d;
            shift_q        <= shift_d;
            bytes_left_q   <= bytes_left_d;
            idx_q          <= idx_d;
            phase_q        <= phase_d;
            cycle_cnt_q    <= cycle_cnt_d;
            tx_data_q      <= tx_data_d;
            tx_start_q     <= tx_start_d;
            mips_enable_q  <= mips_enable_d;
            mips_reset_q   <= mips_reset_d;
            dbg_reg_addr_q <= dbg_reg_addr_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
        end
    end

    assign bus.tx_data      = tx_data_q;
    assign bus.tx_start     = tx_start_q;
    assign bus.mips_enable  = mips_enable_q;
    assign bus.mips_reset   = mips_reset_q;
    assign bus.dbg_reg_addr = dbg_reg_addr_q;
    assign bus.imem_we      = imem_we_q;
    assign bus.imem_addr    = imem_addr_q;
    assign bus.imem_wdata   = imem_wdata_q;
endmodule

// File: doc/debug_unit.md
Name: debug_unit

Overview:
- Host-facing control stage sitting directly upstream of the pipelined processor core: the processor only advances when this block says so.
- Takes command bytes from a UART receiver and loads programs into instruction memory.
- Gates the processor clock enable for single-step or run-to-halt.
- After each step or run, streams a state dump (PC, cycle count, 32 GPRs) back through a UART transmitter.

Parameters:
- PC_W, 10, PC / instruction-memory address width.
- NREGS, 32, number of general-purpose registers dumped.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; the only reset of this block.
- rx_data  in  8  received byte, valid when rx_done=1.
- rx_done  in  1  one-cycle pulse, byte received.
- tx_data  out  8  byte to transmit.
- tx_start  out  1  one-cycle pulse, start transmitting tx_data.
- tx_done  in  1  one-cycle pulse, transmitter finished current byte.
- mips_enable  out  1  processor clock enable (pipeline latches, PC write).
- mips_reset  out  1  processor synchronous reset pulse.
- halt  in  1  processor has reached its halt instruction (level).
- pc_value  in  PC_W  current processor PC.
- dbg_reg_addr  out  5  register-file debug read address.
- dbg_reg_data  in  32  register-file debug read data, combinational from dbg_reg_addr.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  PC_W  instruction-memory write address.
- imem_wdata  out  32  instruction-memory write data.

Behaviour:
- Reset (async): state=IDLE.
  - All outputs 0, including mips_enable, mips_reset, imem_we, tx_start; dbg_reg_addr=0; tx_data=0.
  - cycle_cnt=0.
  - Any partial load or dump is abandoned.
- States: IDLE, LD_HI, LD_LO, LD_BYTE, LD_WR, RUN, STEP, RST, DUMP_LOAD, DUMP_SEND, DUMP_WAIT, ACK_SEND, ACK_WAIT.
- IDLE: on rx_done, decode rx_data:
  - 0x4C 'L' → LD_HI.
  - 0x43 'C' → RUN.
  - 0x53 'S' → STEP.
  - 0x52 'R' → RST.
  - Any other byte is ignored; stay IDLE.
- Load:
  - LD_HI, LD_LO capture a word count N, MSB first; only bits [PC_W-1:0] are used.
  - N=0 → ACK_SEND directly. Otherwise LD_BYTE with addr=0 and byte index=0.
  - LD_BYTE shifts in 4 bytes MSB first. On the 4th byte → LD_WR.
  - LD_WR: imem_we=1 for exactly one cycle, with imem_addr=addr and imem_wdata=the assembled word. Then addr+1, decrement N.
  - When N reaches 0 → ACK_SEND, else back to LD_BYTE.
  - Addresses wrap modulo 2^PC_W.
- RUN:
  - If halt=1 on entry: no enable cycles; go to DUMP_LOAD.
  - Otherwise mips_enable=1 every cycle until halt is sampled 1. mips_enable drops the cycle after halt is seen, then DUMP_LOAD.
  - rx_done is ignored while running.
- STEP: mips_enable=1 for exactly one cycle (suppressed if halt=1), then DUMP_LOAD.
- cycle_cnt: 32-bit, +1 on every cycle with mips_enable=1, wraps 0xFFFFFFFF→0.
- RST: mips_reset=1 for one cycle, cycle_cnt←0, then ACK_SEND.
- Dump frame, 134 bytes, all fields MSB first:
  - 2 bytes PC, zero-extended to 16 bits.
  - 4 bytes cycle_cnt.
  - Then for r=0..NREGS-1: dbg_reg_addr=r, 4 bytes of dbg_reg_data.
- DUMP_LOAD: captures the next 32-bit word (or the PC / count field) into a shift register. For registers, dbg_reg_data is sampled in the cycle dbg_reg_addr=r is presented.
- Byte transmit handshake:
  - DUMP_SEND drives tx_data and pulses tx_start for one cycle.
  - DUMP_WAIT holds tx_data stable until tx_done.
  - After the last byte → IDLE.
  - tx_done outside a WAIT state is ignored.
- ACK_SEND/ACK_WAIT: transmit a single byte 0x06 with the same handshake, then IDLE.
- Simultaneous events:
  - rx_done is only honoured in IDLE, LD_HI, LD_LO and LD_BYTE.
  - A reset asserted during any state wins immediately.
- No combinational path from rx_* to tx_* or mips_* outputs; all outputs are registered except dbg_reg_addr, which is registered as well.

Test Plan:
- Reset mid-LD_BYTE (after 2 of 4 bytes) → imem_we never pulses; state IDLE; all outputs 0; a following 'L',0x00,0x01,11 22 33 44 → one imem_we with addr 0, wdata 0x11223344; then tx byte 0x06.
- Load with N=3, words 0xAAAA0001..0xAAAA0003 → three single-cycle imem_we pulses at addr 0,1,2 with the matching data; one ACK 0x06; no mips_enable activity.
- 'S' with halt=0, pc_value=0x005 → exactly 1 mips_enable cycle; frame starts with 00 05 00 00 00 01; 134 bytes total; each tx_start waits for the preceding tx_done.
- 'C' with halt rising after 7 enable cycles → mips_enable high for 7 cycles, then 0; dumped cycle_cnt = previous+7; 'C' issued again with halt=1 → 0 enable cycles, same count re-dumped.
- 'R' → mips_reset one-cycle pulse, ACK 0x06; next 'S' dumps cycle_cnt=1; unknown byte 0x7A → no tx_start, no mips_enable.
- Force cycle_cnt=0xFFFFFFFF, then 'S' → dumped count 00 00 00 00; register bytes match dbg_reg_data for r=0..31 in order.
